// File: rtl/led_frame_receiver_pkg.sv
// Shared definitions for the LED frame receiver: receive FSM states,
// frame length, bit-counter limits and the hex-to-segment table.
package led_frame_receiver_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } rx_state_t;

   localparam int unsigned FRAME_LEN = 64;

   // Bit counter: exact-frame value and saturation value (one past a full frame)
   localparam logic [6:0] BIT_CNT_FULL = 7'(FRAME_LEN);
   localparam logic [6:0] BIT_CNT_SAT  = 7'(FRAME_LEN + 1);

   // Active-low segment patterns {g,f,e,d,c,b,a}, index 0 is hex digit 0
   localparam logic [0:15][6:0] HEX_SEG = {
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
      return HEX_SEG[value];
   endfunction

endpackage

// File: rtl/led_frame_receiver_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input, followed by a history
// flop that turns level changes into single-cycle rise/fall pulses.
module sync_edge_det #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic CLK,
   input  logic RESET,
   input  logic D,
   output logic RISE,
   output logic FALL
);

   logic sync_meta;
   logic sync_q;
   logic sync_prev;

   // Synchronize the pin and keep one cycle of history for edge detection
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         sync_meta <= RESET_VAL;
         sync_q    <= RESET_VAL;
         sync_prev <= RESET_VAL;
      end else begin
         sync_meta <= D;
         sync_q    <= sync_meta;
         sync_prev <= sync_q;
      end
   end

   assign RISE = sync_q & ~sync_prev;
   assign FALL = ~sync_q & sync_prev;

endmodule

// File: rtl/led_frame_receiver.sv
// Serial 64-bit frame receiver driving an 8-digit multiplexed 7-segment
// display. Frames are accepted only when exactly 64 bits arrive between the
// LED_CS falling and rising edges; the display scans continuously.
module led_frame_receiver
   import led_frame_receiver_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       SCLK,
   input  logic       MOSI,
   input  logic       LED_CS,
   output logic [7:0] AN,
   output logic [6:0] SEG,
   output logic       DP,
   output logic       FRAME_DONE,
   output logic       FRAME_ERR
);

   localparam int unsigned SCAN_W = $clog2(REFRESH_DIV);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_DIV - 1);

   logic                 sclk_rise;
   logic                 cs_rise;
   logic                 cs_fall;
   logic                 mosi_meta;
   logic                 mosi_s;

   rx_state_t            state;
   logic [6:0]           bit_cnt;
   logic [FRAME_LEN-1:0] shift_reg;
   logic [FRAME_LEN-1:0] disp_reg;

   logic [SCAN_W-1:0]    scan_cnt;
   logic [2:0]           digit_idx;

   sync_edge_det #(.RESET_VAL(1'b0)) u_sclk_sync (
      .CLK   (CLK),
      .RESET (RESET),
      .D     (SCLK),
      .RISE  (sclk_rise),
      .FALL  ()
   );

   sync_edge_det #(.RESET_VAL(1'b1)) u_cs_sync (
      .CLK   (CLK),
      .RESET (RESET),
      .D     (LED_CS),
      .RISE  (cs_rise),
      .FALL  (cs_fall)
   );

   // Delay MOSI by the same two stages as SCLK so the captured bit is the
   // value present at the SCLK rising edge
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         mosi_meta <= 1'b0;
         mosi_s    <= 1'b0;
      end else begin
         mosi_meta <= MOSI;
         mosi_s    <= mosi_meta;
      end
   end

   // Receive FSM: shift bits while selected, then commit or reject the frame
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         disp_reg   <= '0;
         FRAME_DONE <= 1'b0;
         FRAME_ERR  <= 1'b0;
      end else begin
         FRAME_DONE <= 1'b0;
         FRAME_ERR  <= 1'b0;
         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state   <= SHIFT;
                  bit_cnt <= '0;
               end
            end
            SHIFT: begin
               // End of frame takes priority; a coincident SCLK edge is dropped
               if (cs_rise) begin
                  state <= CHECK;
               end else if (sclk_rise) begin
                  shift_reg <= {shift_reg[FRAME_LEN-2:0], mosi_s};
                  if (bit_cnt != BIT_CNT_SAT) begin
                     bit_cnt <= bit_cnt + 7'd1;
                  end
               end
            end
            CHECK: begin
               if (bit_cnt == BIT_CNT_FULL) begin
                  disp_reg   <= shift_reg;
                  FRAME_DONE <= 1'b1;
               end else begin
                  FRAME_ERR  <= 1'b1;
               end
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Digit scanner: on each refresh wrap, light the next digit and load its
   // segments and decimal point on the same edge as the anode change
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         scan_cnt  <= '0;
         digit_idx <= '0;
         AN        <= '1;
         SEG       <= '1;
         DP        <= 1'b1;
      end else begin
         if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 3'd1;
            AN        <= ~(8'h01 << digit_idx);
            SEG       <= hex_to_seg(disp_reg[{digit_idx, 3'b000} +: 4]);
            DP        <= ~disp_reg[{digit_idx, 3'b111}];
         end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_led_frame_receiver.sv
// Directed self-checking bench for led_frame_receiver with a short refresh
// period so the digit scan can be observed in a few dozen cycles.
module tb_led_frame_receiver;

   localparam int unsigned DIV = 4;

   logic       CLK;
   logic       RESET;
   logic       SCLK;
   logic       MOSI;
   logic       LED_CS;
   logic [7:0] AN;
   logic [6:0] SEG;
   logic       DP;
   logic       FRAME_DONE;
   logic       FRAME_ERR;

   int tests_run    = 0;
   int tests_failed = 0;
   int done_seen    = 0;
   int err_seen     = 0;

   led_frame_receiver #(.REFRESH_DIV(DIV)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .SCLK       (SCLK),
      .MOSI       (MOSI),
      .LED_CS     (LED_CS),
      .AN         (AN),
      .SEG        (SEG),
      .DP         (DP),
      .FRAME_DONE (FRAME_DONE),
      .FRAME_ERR  (FRAME_ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Running totals of result pulses, sampled away from the active edge
   always @(negedge CLK) begin
      if (FRAME_DONE === 1'b1) done_seen = done_seen + 1;
      if (FRAME_ERR === 1'b1)  err_seen  = err_seen + 1;
   end

   task automatic clock_bit(input logic b);
      MOSI = b;
      repeat (4) @(negedge CLK);
      SCLK = 1'b1;
      repeat (4) @(negedge CLK);
      SCLK = 1'b0;
   endtask

   // Send bits data[n-1]..data[0]; with coincide set, the last SCLK rise and
   // the LED_CS rise are driven together. Reports result-pulse timing.
   task automatic run_frame(input logic [64:0] data, input int n, input bit coincide,
                            output int lat, output int ndone, output int nerr);
      lat = -1; ndone = 0; nerr = 0;
      @(negedge CLK);
      LED_CS = 1'b0;
      repeat (6) @(negedge CLK);
      for (int i = n - 1; i >= 0; i--) begin
         if (coincide && i == 0) begin
            MOSI = data[i];
            repeat (4) @(negedge CLK);
         end else begin
            clock_bit(data[i]);
         end
      end
      if (coincide) begin
         SCLK   = 1'b1;
         LED_CS = 1'b1;
      end else begin
         repeat (4) @(negedge CLK);
         LED_CS = 1'b1;
      end
      for (int c = 1; c <= 12; c++) begin
         @(negedge CLK);
         if (FRAME_DONE === 1'b1 || FRAME_ERR === 1'b1) begin
            if (lat < 0) lat = c;
         end
         if (FRAME_DONE === 1'b1) ndone++;
         if (FRAME_ERR === 1'b1)  nerr++;
      end
      SCLK = 1'b0;
   endtask

   task automatic check_digit(input int k, input logic [6:0] exp_seg, input logic exp_dp,
                              input string tag);
      logic [7:0] exp_an;
      bit found;
      exp_an = ~(8'h01 << k);
      found  = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge CLK);
         if (AN === exp_an) found = 1'b1;
      end
      tests_run++;
      if (!found) begin
         tests_failed++;
         $display("FAIL %s_an digit %0d: AN last %h, required %h within 40 cycles", tag, k, AN, exp_an);
      end else begin
         tests_run++;
         if (SEG !== exp_seg) begin
            tests_failed++;
            $display("FAIL %s_seg digit %0d: got %h, required %h", tag, k, SEG, exp_seg);
         end
         tests_run++;
         if (DP !== exp_dp) begin
            tests_failed++;
            $display("FAIL %s_dp digit %0d: got %b, required %b", tag, k, DP, exp_dp);
         end
      end
   endtask

   task automatic check_result(input string tag, input int lat, input int ndone, input int nerr,
                               input int exp_done, input int exp_err);
      tests_run++;
      if (lat !== 4) begin
         tests_failed++;
         $display("FAIL %s_latency: got %0d cycles, required 4", tag, lat);
      end
      tests_run++;
      if (ndone !== exp_done) begin
         tests_failed++;
         $display("FAIL %s_done_count: got %0d, required %0d", tag, ndone, exp_done);
      end
      tests_run++;
      if (nerr !== exp_err) begin
         tests_failed++;
         $display("FAIL %s_err_count: got %0d, required %0d", tag, nerr, exp_err);
      end
   endtask

   task automatic test_reset();
      RESET = 1'b0; SCLK = 1'b0; MOSI = 1'b0; LED_CS = 1'b1;
      repeat (3) @(negedge CLK);
      tests_run++;
      if (AN !== 8'hFF) begin tests_failed++; $display("FAIL reset_an: got %h, required ff", AN); end
      tests_run++;
      if (SEG !== 7'h7F) begin tests_failed++; $display("FAIL reset_seg: got %h, required 7f", SEG); end
      tests_run++;
      if (DP !== 1'b1) begin tests_failed++; $display("FAIL reset_dp: got %b, required 1", DP); end
      tests_run++;
      if (FRAME_DONE !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b, required 0", FRAME_DONE); end
      tests_run++;
      if (FRAME_ERR !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b, required 0", FRAME_ERR); end
   endtask

   task automatic test_scan();
      logic [7:0] exp_an;
      @(negedge CLK);
      RESET = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge CLK);
         tests_run++;
         if (AN !== 8'hFF) begin
            tests_failed++;
            $display("FAIL scan_pre_wrap cycle %0d: AN %h, required ff", c, AN);
         end
      end
      for (int d = 0; d < 9; d++) begin
         exp_an = ~(8'h01 << (d % 8));
         for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            tests_run++;
            if (AN !== exp_an) begin
               tests_failed++;
               $display("FAIL scan_step %0d.%0d: AN %h, required %h", d, c, AN, exp_an);
            end
         end
      end
   endtask

   task automatic test_good_frame();
      int lat, nd, ne;
      run_frame({1'b0, 64'h0F0E_0D0C_8B0A_0908}, 64, 1'b0, lat, nd, ne);
      check_result("good", lat, nd, ne, 1, 0);
      repeat (34) @(negedge CLK);
      check_digit(7, 7'h0E, 1'b1, "good");
      check_digit(5, 7'h21, 1'b1, "good");
      check_digit(3, 7'h03, 1'b0, "good");
      check_digit(0, 7'h00, 1'b1, "good");
   endtask

   task automatic test_bad_lengths();
      int lat, nd, ne;
      run_frame({1'b0, 64'h1234_5678_9ABC_DEF0}, 63, 1'b0, lat, nd, ne);
      check_result("short63", lat, nd, ne, 0, 1);
      run_frame(65'h1_FFFF_0000_5555_AAAA, 65, 1'b0, lat, nd, ne);
      check_result("long65", lat, nd, ne, 0, 1);
      repeat (34) @(negedge CLK);
      check_digit(7, 7'h0E, 1'b1, "bad_keep");
      check_digit(3, 7'h03, 1'b0, "bad_keep");
      check_digit(0, 7'h00, 1'b1, "bad_keep");
   endtask

   task automatic test_coincident_edge();
      int lat, nd, ne;
      run_frame({1'b0, 64'h0102_0304_0506_0708}, 64, 1'b1, lat, nd, ne);
      check_result("coincide", lat, nd, ne, 0, 1);
      repeat (34) @(negedge CLK);
      check_digit(7, 7'h0E, 1'b1, "coin_keep");
   endtask

   task automatic test_idle_sclk();
      int d0, e0;
      d0 = done_seen; e0 = err_seen;
      for (int i = 0; i < 6; i++) clock_bit(1'b1);
      repeat (10) @(negedge CLK);
      tests_run++;
      if (done_seen - d0 !== 0 || err_seen - e0 !== 0) begin
         tests_failed++;
         $display("FAIL idle_sclk: done %0d err %0d pulses, required 0 and 0", done_seen - d0, err_seen - e0);
      end
   endtask

   task automatic test_reset_mid_frame();
      int lat, nd, ne, d0, e0;
      @(negedge CLK);
      LED_CS = 1'b0;
      repeat (6) @(negedge CLK);
      for (int i = 0; i < 30; i++) clock_bit(i[0]);
      RESET = 1'b0;
      repeat (2) @(negedge CLK);
      tests_run++;
      if (AN !== 8'hFF) begin tests_failed++; $display("FAIL midreset_an: got %h, required ff", AN); end
      LED_CS = 1'b1;
      repeat (3) @(negedge CLK);
      RESET = 1'b1;
      d0 = done_seen; e0 = err_seen;
      repeat (10) @(negedge CLK);
      tests_run++;
      if (done_seen - d0 !== 0 || err_seen - e0 !== 0) begin
         tests_failed++;
         $display("FAIL midreset_quiet: done %0d err %0d pulses, required 0 and 0", done_seen - d0, err_seen - e0);
      end
      run_frame(65'h0, 64, 1'b0, lat, nd, ne);
      check_result("zero", lat, nd, ne, 1, 0);
      repeat (34) @(negedge CLK);
      for (int k = 0; k < 8; k++) check_digit(k, 7'h40, 1'b1, "zero");
   endtask

   initial begin
      test_reset();
      test_scan();
      test_good_frame();
      test_bad_lengths();
      test_coincident_edge();
      test_idle_sclk();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
